// File: rtl/ambilight_pkg.sv
// Shared definitions for the ambilight zone RAM writer.
//   BE_RGB / BE_ALL : ram_mm byteenable patterns for zone colour words and the status word
//   fsm_state_e     : flush sequencer states
//   pack_rgb        : builds a zone colour word {8'h00, R, G, B}
//   pack_status     : builds the status word {frame_count, 7'd0, frame_drop, 8'd0}
package ambilight_pkg;

    localparam logic [3:0] BE_RGB = 4'b0111;
    localparam logic [3:0] BE_ALL = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        STATUS
    } fsm_state_e;

    function automatic logic [31:0] pack_rgb(input logic [7:0] r, input logic [7:0] g,
                                             input logic [7:0] b);
        return {8'h00, r, g, b};
    endfunction

    function automatic logic [31:0] pack_status(input logic [15:0] count, input logic drop);
        return {count, 7'd0, drop, 8'd0};
    endfunction

endpackage

// File: rtl/zone_sum_bank.sv
// Per-zone R/G/B accumulators with a snapshot of averaged colours.
//   clk_i, rst_ni      : clock, async active-low reset
//   pix_valid_i        : pixel qualifier; pixels with pix_zone_i >= NUM_ZONES are ignored
//   pix_zone_i         : zone index of the pixel
//   pix_r/g/b_i        : pixel colour
//   snapshot_i         : capture averages of the live sums (including this cycle's pixel)
//   clear_i            : zero all live sums at the end of this cycle
//   rd_idx_i           : zone selected for readout
//   rd_rgb_o           : {R, G, B} averages of the selected zone from the snapshot
module zone_sum_bank
    import ambilight_pkg::*;
#(
    parameter int unsigned NUM_ZONES     = 32,
    parameter int unsigned ZONE_W        = 6,
    parameter int unsigned ZONE_PIX_LOG2 = 12
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              pix_valid_i,
    input  logic [ZONE_W-1:0] pix_zone_i,
    input  logic [7:0]        pix_r_i,
    input  logic [7:0]        pix_g_i,
    input  logic [7:0]        pix_b_i,
    input  logic              snapshot_i,
    input  logic              clear_i,
    input  logic [ZONE_W-1:0] rd_idx_i,
    output logic [23:0]       rd_rgb_o
);

    localparam int unsigned SW = 8 + ZONE_PIX_LOG2;
    typedef logic [SW-1:0] sum_t;

    // Index 0 = R, 1 = G, 2 = B.
    sum_t       live_q   [NUM_ZONES][3];
    sum_t       live_d   [NUM_ZONES][3];
    sum_t       acc      [NUM_ZONES][3];
    // Only the averaged byte is kept: the sum is 8+ZONE_PIX_LOG2 bits, so its top 8 bits
    // are already min(sum >> ZONE_PIX_LOG2, 255).
    logic [7:0] shadow_q [NUM_ZONES][3];
    logic [7:0] shadow_d [NUM_ZONES][3];
    logic [7:0] px       [3];
    logic       hit;

    assign px[0] = pix_r_i;
    assign px[1] = pix_g_i;
    assign px[2] = pix_b_i;
    assign hit   = pix_valid_i && (32'(pix_zone_i) < NUM_ZONES);

    function automatic sum_t sat_add(input sum_t a, input logic [7:0] p);
        logic [SW:0] s;
        s = {1'b0, a} + (SW + 1)'(p);
        return s[SW] ? '1 : s[SW-1:0];
    endfunction

    always_comb begin
        for (int unsigned z = 0; z < NUM_ZONES; z++) begin
            for (int c = 0; c < 3; c++) begin
                acc[z][c] = live_q[z][c];
                if (hit && (32'(pix_zone_i) == z)) begin
                    acc[z][c] = sat_add(live_q[z][c], px[c]);
                end
                live_d[z][c]   = clear_i ? '0 : acc[z][c];
                shadow_d[z][c] = snapshot_i ? acc[z][c][SW-1:ZONE_PIX_LOG2] : shadow_q[z][c];
            end
        end
    end

    always_comb begin
        rd_rgb_o = '0;
        for (int unsigned z = 0; z < NUM_ZONES; z++) begin
            if (32'(rd_idx_i) == z) begin
                rd_rgb_o = {shadow_q[z][0], shadow_q[z][1], shadow_q[z][2]};
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned z = 0; z < NUM_ZONES; z++) begin
                for (int c = 0; c < 3; c++) begin
                    live_q[z][c]   <= '0;
                    shadow_q[z][c] <= '0;
                end
            end
        end else begin
            live_q   <= live_d;
            shadow_q <= shadow_d;
        end
    end

endmodule

// File: rtl/ambilight_zone_ram_writer.sv
// Accumulates per-zone colour sums from the pixel stream and, on each frame_end, writes one
// averaged colour word per zone followed by a status word into the ram_mm slave.
//   clk_clk, reset_reset_n  : clock, async active-low reset
//   pix_valid/pix_zone/pix_r/pix_g/pix_b : pixel stream
//   frame_end               : 1-cycle pulse after the last pixel of a frame
//   ram_mm_*                : word-addressed write port (no backpressure)
//   flush_busy              : high during zone and status writes
//   flush_done              : 1-cycle pulse after the status word
//   frame_drop              : sticky, a frame_end arrived while a flush was in progress
//   frame_count             : number of completed flushes (wraps)
module ambilight_zone_ram_writer
    import ambilight_pkg::*;
#(
    parameter int unsigned NUM_ZONES     = 32,
    parameter int unsigned ZONE_W        = 6,
    parameter int unsigned ZONE_PIX_LOG2 = 12,
    parameter int unsigned ADDR_W        = 13,
    parameter int unsigned BASE_ADDR     = 0
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              pix_valid,
    input  logic [ZONE_W-1:0] pix_zone,
    input  logic [7:0]        pix_r,
    input  logic [7:0]        pix_g,
    input  logic [7:0]        pix_b,
    input  logic              frame_end,
    output logic [ADDR_W-1:0] ram_mm_address,
    output logic              ram_mm_chipselect,
    output logic              ram_mm_clken,
    output logic              ram_mm_write,
    output logic [31:0]       ram_mm_writedata,
    output logic [3:0]        ram_mm_byteenable,
    output logic              flush_busy,
    output logic              flush_done,
    output logic              frame_drop,
    output logic [15:0]       frame_count
);

    fsm_state_e        state_q, state_d;
    logic [ZONE_W-1:0] idx_q, idx_d;
    logic              frame_drop_q, frame_drop_d;
    logic [15:0]       frame_count_q, frame_count_d;
    logic              flush_done_q, flush_done_d;
    logic              snapshot;
    logic [23:0]       rd_rgb;

    // Only an idle frame_end starts a new snapshot; a frame_end during a flush still clears the
    // live sums so the next frame starts from zero, but the snapshot being written is preserved.
    assign snapshot = (state_q == IDLE) && frame_end;

    zone_sum_bank #(
        .NUM_ZONES     (NUM_ZONES),
        .ZONE_W        (ZONE_W),
        .ZONE_PIX_LOG2 (ZONE_PIX_LOG2)
    ) u_bank (
        .clk_i       (clk_clk),
        .rst_ni      (reset_reset_n),
        .pix_valid_i (pix_valid),
        .pix_zone_i  (pix_zone),
        .pix_r_i     (pix_r),
        .pix_g_i     (pix_g),
        .pix_b_i     (pix_b),
        .snapshot_i  (snapshot),
        .clear_i     (frame_end),
        .rd_idx_i    (idx_q),
        .rd_rgb_o    (rd_rgb)
    );

    always_comb begin
        state_d           = state_q;
        idx_d             = idx_q;
        ram_mm_address    = '0;
        ram_mm_chipselect = 1'b0;
        ram_mm_clken      = 1'b0;
        ram_mm_write      = 1'b0;
        ram_mm_writedata  = '0;
        ram_mm_byteenable = '0;

        unique case (state_q)
            IDLE: begin
                if (frame_end) begin
                    state_d = FLUSH;
                    idx_d   = '0;
                end
            end
            FLUSH: begin
                ram_mm_chipselect = 1'b1;
                ram_mm_clken      = 1'b1;
                ram_mm_write      = 1'b1;
                ram_mm_address    = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_q);
                ram_mm_writedata  = pack_rgb(rd_rgb[23:16], rd_rgb[15:8], rd_rgb[7:0]);
                ram_mm_byteenable = BE_RGB;
                if (32'(idx_q) == NUM_ZONES - 1) begin
                    state_d = STATUS;
                end else begin
                    idx_d = idx_q + ZONE_W'(1);
                end
            end
            STATUS: begin
                ram_mm_chipselect = 1'b1;
                ram_mm_clken      = 1'b1;
                ram_mm_write      = 1'b1;
                ram_mm_address    = ADDR_W'(BASE_ADDR) + ADDR_W'(NUM_ZONES);
                ram_mm_writedata  = pack_status(frame_count_q + 16'd1, frame_drop_q);
                ram_mm_byteenable = BE_ALL;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        frame_drop_d  = frame_drop_q | (frame_end && (state_q != IDLE));
        frame_count_d = (state_q == STATUS) ? frame_count_q + 16'd1 : frame_count_q;
        flush_done_d  = (state_q == STATUS);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            frame_drop_q  <= 1'b0;
            frame_count_q <= '0;
            flush_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            frame_drop_q  <= frame_drop_d;
            frame_count_q <= frame_count_d;
            flush_done_q  <= flush_done_d;
        end
    end

    assign flush_busy  = (state_q != IDLE);
    assign flush_done  = flush_done_q;
    assign frame_drop  = frame_drop_q;
    assign frame_count = frame_count_q;

endmodule
